// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and state encoding for the FIR output path.
package fir_pkg;
    localparam int FIR_DATA_W       = 16;
    localparam int BYTES_PER_SAMPLE = FIR_DATA_W / 8;
    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: register FIFO; level alone tells full from empty, and a
// write on full is legal when a read happens in the same cycle.
module fir_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [LW-1:0]     level
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end
endmodule

// File: rtl/fir_out_serializer.sv
// fir_out_serializer: buffers filter samples and streams them MSB-first as
// bytes; never stalls the filter, drops on full and flags a sticky ovf.
module fir_out_serializer
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = 4,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [LW-1:0]     level
);
    localparam int NB = DATA_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    state_t            state;
    logic [IW-1:0]     byte_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rd_data;
    logic              full, has_data, last, pop, wr_en, drop;

    assign full     = level == LW'(DEPTH);
    assign has_data = level != '0;
    assign last     = byte_idx == IW'(NB - 1);
    // SEND always has m_valid high, so m_ready alone marks a transfer there
    assign pop      = has_data && (state == IDLE || (m_ready && last));
    assign wr_en    = s_valid && (!full || pop);
    assign drop     = s_valid && full && !pop;

    fir_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            shreg    <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_first  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf;
            if (pop) begin
                state    <= SEND;
                byte_idx <= '0;
                shreg    <= rd_data << 8;
                m_data   <= rd_data[DATA_W-1 -: 8];
                m_valid  <= 1'b1;
                m_first  <= 1'b1;
            end else if (state == SEND && m_ready && !last) begin
                byte_idx <= byte_idx + IW'(1);
                shreg    <= shreg << 8;
                m_data   <= shreg[DATA_W-1 -: 8];
                m_first  <= 1'b0;
            end else if (state == SEND && m_ready) begin
                state    <= IDLE;
                m_valid  <= 1'b0;
                m_first  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_serializer.sv
// tb_fir_out_serializer: randomized scenarios checked against a sample-level
// queue model of the buffer and byte sequencer.
module tb_fir_out_serializer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0, m_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_first, ovf;
    logic [2:0]  level;

    int vectors = 0, errors = 0;

    fir_out_serializer dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_first(m_first), .ovf(ovf), .ovf_clr(ovf_clr), .level(level)
    );

    always #5 clk = ~clk;

    // Model: queued samples, the sample on the wire, bytes of it still to send
    logic [15:0] q[$];
    logic [15:0] cur;
    int          rem;
    logic        m_ovf;
    bit          mx, mp, mfull;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            rem   = 0;
            cur   = '0;
            m_ovf = 1'b0;
        end else begin
            mx    = rem > 0 && m_ready;
            mp    = q.size() > 0 && (rem == 0 || (mx && rem == 1));
            mfull = q.size() == 4;
            if (s_valid && mfull && !mp) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (mp) begin
                cur = q.pop_front();
                rem = 2;
            end else if (mx) rem--;
            if (s_valid && (!mfull || mp)) q.push_back(s_data);
        end
    end

    function automatic logic [13:0] mdl();
        return {rem > 0, rem == 2, rem == 2 ? cur[15:8] : rem == 1 ? cur[7:0] : 8'h00,
                3'(q.size()), m_ovf};
    endfunction

    function automatic logic [13:0] obs();
        return {m_valid, m_first, m_valid ? m_data : 8'h00, level, ovf};
    endfunction

    task automatic step(input logic sv, input logic [15:0] sd, input logic rdy, input logic clr);
        s_valid = sv;
        s_data  = sd;
        m_ready = rdy;
        ovf_clr = clr;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (rem > 0 || q.size() > 0); i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_valid, m_first, m_data, ovf, level} !== 13'd0) begin
            errors++;
            $display("FAIL reset: got v%b f%b d%h o%b l%0d, want all 0", m_valid, m_first, m_data, ovf, level);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        step(1, 16'hA55A, 1, 0);
        vectors++;
        if (level !== 3'd1 || m_valid !== 1'b0 || obs() !== mdl()) begin
            errors++;
            $display("FAIL single_write: got l%0d v%b, want l1 v0", level, m_valid);
        end
        step(0, 0, 1, 0);
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b11, 8'hA5} || obs() !== mdl()) begin
            errors++;
            $display("FAIL single_msb: got v%b f%b d%h, want v1 f1 dA5", m_valid, m_first, m_data);
        end
        step(0, 0, 1, 0);
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b10, 8'h5A} || obs() !== mdl()) begin
            errors++;
            $display("FAIL single_lsb: got v%b f%b d%h, want v1 f0 d5A", m_valid, m_first, m_data);
        end
        step(0, 0, 1, 0);
        vectors++;
        if (m_valid !== 1'b0 || obs() !== mdl()) begin
            errors++;
            $display("FAIL single_idle: got v%b, want v0", m_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        step(1, 16'hBEEF, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            vectors++;
            if ({m_valid, m_first, m_data} !== {2'b11, 8'hBE} || obs() !== mdl()) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got v%b f%b d%h, want v1 f1 dBE", i, m_valid, m_first, m_data);
            end
        end
        step(0, 0, 1, 0);
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b10, 8'hEF} || obs() !== mdl()) begin
            errors++;
            $display("FAIL backpressure_release: got v%b f%b d%h, want v1 f0 dEF", m_valid, m_first, m_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        for (int i = 1; i <= 6; i++) begin
            step(1, 16'(i), 0, 0);
            vectors++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL overflow_fill[%0d]: got %h want %h", i, obs(), mdl());
            end
        end
        vectors++;
        if (level !== 3'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got l%0d o%b, want l4 o1", level, ovf);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (ovf !== 1'b0 || obs() !== mdl()) begin
            errors++;
            $display("FAIL overflow_clear: got o%b, want o0", ovf);
        end
        for (int i = 0; i < 40 && (m_valid || level != 0); i++) begin
            if (m_valid) b.push_back(m_data);
            step(0, 0, 1, 0);
        end
        vectors++;
        if (b.size() != 10) begin
            errors++;
            $display("FAIL overflow_drain_count: got %0d bytes want 10", b.size());
        end
        for (int i = 0; i < 5 && b.size() == 10; i++) begin
            vectors++;
            if ({b[2*i], b[2*i+1]} !== 16'(i + 1)) begin
                errors++;
                $display("FAIL overflow_order[%0d]: got %h want %h", i, {b[2*i], b[2*i+1]}, 16'(i + 1));
            end
        end
        drain();
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 0);
        step(0, 0, 1, 0);
        step(1, 16'h7777, 1, 0);
        vectors++;
        if (level !== 3'd4 || ovf !== 1'b0 || m_first !== 1'b1 || obs() !== mdl()) begin
            errors++;
            $display("FAIL full_simul: got l%0d o%b f%b, want l4 o0 f1", level, ovf, m_first);
        end
        drain();
        vectors++;
        if (obs() !== mdl() || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_simul_drain: got %h want %h", obs(), mdl());
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) step(1, 16'($urandom), 0, 0);
        vectors++;
        if (level !== 3'd3 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got l%0d v%b, want l3 v1", level, m_valid);
        end
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_valid, m_first, ovf, level} !== 6'd0) begin
            errors++;
            $display("FAIL midreset_async: got v%b f%b o%b l%0d, want 0", m_valid, m_first, ovf, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h1234, 1, 0);
        step(0, 0, 1, 0);
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b11, 8'h12} || obs() !== mdl()) begin
            errors++;
            $display("FAIL midreset_msb: got v%b f%b d%h, want v1 f1 d12", m_valid, m_first, m_data);
        end
        step(0, 0, 1, 0);
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b10, 8'h34} || obs() !== mdl()) begin
            errors++;
            $display("FAIL midreset_lsb: got v%b f%b d%h, want v1 f0 d34", m_valid, m_first, m_data);
        end
        drain();
    endtask

    task automatic test_streaming();
        logic [7:0]  exp_b[$], got[$];
        logic [15:0] smp;
        int          gaps = 0, bad = 0;
        for (int i = 0; i < 100; i++) begin
            smp = 16'($urandom);
            exp_b.push_back(smp[15:8]);
            exp_b.push_back(smp[7:0]);
            for (int c = 0; c < 2; c++) begin
                if (m_valid) got.push_back(m_data);
                else if (got.size() > 0) gaps++;
                step(c == 0, smp, 1, 0);
                if (obs() !== mdl()) bad++;
            end
        end
        for (int i = 0; i < 20 && got.size() < 200; i++) begin
            if (m_valid) got.push_back(m_data);
            else if (got.size() > 0) gaps++;
            step(0, 0, 1, 0);
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_model: got %0d cycle mismatches want 0", bad);
        end
        vectors++;
        if (gaps != 0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL stream_gaps: got %0d gaps ovf %b, want 0 gaps ovf 0", gaps, ovf);
        end
        vectors++;
        if (got.size() != 200) begin
            errors++;
            $display("FAIL stream_count: got %0d bytes want 200", got.size());
        end
        for (int i = 0; i < 200 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL stream_byte[%0d]: got %h want %h", i, got[i], exp_b[i]);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_simul();
        test_reset_midstream();
        test_streaming();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
